// File: rtl/cot_link_tx.sv
// Torus link transmitter: buffers register-write requests and sends each as a
// header/payload flit pair under credit flow control. Optional `COT_LINK_STATS_EN adds pkt_count.
module cot_link_tx #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_dest,
  input  logic [1:0] in_thread,
  input  logic [1:0] in_reg,
  input  logic [7:0] in_data,
  output logic       link_valid,
  output logic       link_head,
  output logic [7:0] link_flit,
  input  logic       credit_in,
  output logic       credit_err
`ifdef COT_LINK_STATS_EN
  ,
  output logic [15:0] pkt_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [3:0]    CRED_MAX = 4'(CREDITS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_r;
  logic [AW-1:0] rd_r;
  logic [CW-1:0] count_r;
  logic [3:0]    credits_r;
  logic [0:0]    state_r;

  logic          push_s;
  logic          pop_s;
  logic          have_req_s;
  logic          credit_ok_s;
  logic          send_hdr_s;
  logic          send_pay_s;
  logic          send_s;
  logic          err_set_s;
  logic [15:0]   head_s;
  logic [0:0]    state_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [3:0]    credits_nxt_s;
  logic [7:0]    flit_nxt_s;

  // Flit scheduling; an empty FIFO forwards the incoming request so a header
  // can leave the cycle after acceptance, and a same-cycle credit is usable.
  always_comb begin
    push_s      = in_valid && in_ready;
    head_s      = (count_r != '0) ? mem_r[rd_r] : {in_dest, in_thread, in_reg, in_data};
    have_req_s  = (count_r != '0) || push_s;
    credit_ok_s = (credits_r != 4'd0) || credit_in;
    send_hdr_s  = 1'b0;
    send_pay_s  = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (have_req_s && credit_ok_s) begin
          send_hdr_s  = 1'b1;
          state_nxt_s = ST_BODY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BODY: begin
        if (credit_ok_s) begin
          send_pay_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    pop_s  = send_pay_s;
    send_s = send_hdr_s || send_pay_s;
  end

  // Next FIFO occupancy and outgoing flit byte.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (send_hdr_s) begin
      flit_nxt_s = head_s[15:8];
    end else if (send_pay_s) begin
      flit_nxt_s = mem_r[rd_r][7:0];
    end else begin
      flit_nxt_s = 8'd0;
    end
  end

  // Credit accounting; a return at full credits with no send is an overflow.
  always_comb begin
    credits_nxt_s = credits_r;
    err_set_s     = 1'b0;
    if (send_s && !credit_in) begin
      credits_nxt_s = credits_r - 4'd1;
    end else if (!send_s && credit_in) begin
      if (credits_r == CRED_MAX) begin
        err_set_s = 1'b1;
      end else begin
        credits_nxt_s = credits_r + 4'd1;
      end
    end else begin
      credits_nxt_s = credits_r;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'd0;
      end
      wr_r    <= '0;
      rd_r    <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_r] <= {in_dest, in_thread, in_reg, in_data};
        wr_r        <= wr_r + AW'(1);
      end
      if (pop_s) begin
        rd_r <= rd_r + AW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // FSM, credits and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      credits_r  <= CRED_MAX;
      credit_err <= 1'b0;
      in_ready   <= 1'b1;
      link_valid <= 1'b0;
      link_head  <= 1'b0;
      link_flit  <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      credits_r  <= credits_nxt_s;
      credit_err <= credit_err || err_set_s;
      in_ready   <= (count_nxt_s != CNT_FULL);
      link_valid <= send_s;
      link_head  <= send_hdr_s;
      link_flit  <= flit_nxt_s;
    end
  end

`ifdef COT_LINK_STATS_EN
  // Completed-packet counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count <= 16'd0;
    end else if (send_pay_s) begin
      pkt_count <= pkt_count + 16'd1;
    end else begin
      pkt_count <= pkt_count;
    end
  end
`endif

  cot_link_tx_chk #(
    .DEPTH  (DEPTH),
    .CREDITS(CREDITS),
    .CW     (CW)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .link_valid(link_valid),
    .link_flit (link_flit),
    .count     (count_r),
    .credits   (credits_r),
    .in_body   (state_r == ST_BODY)
  );

endmodule

// Structural invariants of the transmitter.
module cot_link_tx_chk #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          link_valid,
  input logic [7:0]    link_flit,
  input logic [CW-1:0] count,
  input logic [3:0]    credits,
  input logic          in_body
);

  a_flit_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !link_valid |-> (link_flit == 8'd0));
  a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
    credits <= 4'(CREDITS));
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));
  a_body_has_entry: assert property (@(posedge clk) disable iff (!rst_n)
    in_body |-> (count != '0));

endmodule

// File: tb/tb_cot_link_tx.sv
// Directed self-checking bench for cot_link_tx (DEPTH=4, CREDITS=4).
module tb_cot_link_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_dest;
  logic [1:0] in_thread;
  logic [1:0] in_reg;
  logic [7:0] in_data;
  logic       link_valid;
  logic       link_head;
  logic [7:0] link_flit;
  logic       credit_in;
  logic       credit_err;
`ifdef COT_LINK_STATS_EN
  logic [15:0] pkt_count;
`endif

  int total = 0;
  int bad   = 0;

  logic       exp_v [8];
  logic       exp_h [8];
  logic [7:0] exp_f [8];

  cot_link_tx #(.DEPTH(4), .CREDITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_thread (in_thread),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .link_valid(link_valid),
    .link_head (link_head),
    .link_flit (link_flit),
    .credit_in (credit_in),
    .credit_err(credit_err)
`ifdef COT_LINK_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_val);
    total++;
    assert (obs === exp_val) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_val);
    end
  endtask

  task automatic chk_link(input string tag, input logic v, input logic h, input logic [7:0] f);
    chk({tag, ".valid"}, {15'd0, link_valid}, {15'd0, v});
    chk({tag, ".head"},  {15'd0, link_head},  {15'd0, h});
    chk({tag, ".flit"},  {8'd0, link_flit},   {8'd0, f});
  endtask

  task automatic set_req(input logic [3:0] d, input logic [1:0] t, input logic [1:0] r, input logic [7:0] x);
    in_valid  = 1'b1;
    in_dest   = d;
    in_thread = t;
    in_reg    = r;
    in_data   = x;
  endtask

  task automatic no_req();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, {15'd0, in_ready}, 16'd1);
    chk_link(tag, 1'b0, 1'b0, 8'h00);
    chk({tag, ".credit_err"}, {15'd0, credit_err}, 16'd0);
`ifdef COT_LINK_STATS_EN
    chk({tag, ".pkt_count"}, pkt_count, 16'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; credit_in = 1'b0;
    in_dest = 4'd0; in_thread = 2'd0; in_reg = 2'd0; in_data = 8'd0;
    tick(); tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Single packet: header 0x59 one cycle after accept, then payload.
    set_req(4'd5, 2'd2, 2'd1, 8'hA7);
    chk("single.in_ready", {15'd0, in_ready}, 16'd1);
    tick(); no_req();
    chk_link("single.hdr", 1'b1, 1'b1, 8'h59);
    tick();
    chk_link("single.pay", 1'b1, 1'b0, 8'hA7);
    tick();
    chk_link("single.after", 1'b0, 1'b0, 8'h00);

    // Return the two credits consumed above.
    credit_in = 1'b1; tick(); tick(); credit_in = 1'b0;
    chk("restore.credit_err", {15'd0, credit_err}, 16'd0);

    // Starvation: three packets, four credits.
    set_req(4'd1, 2'd0, 2'd3, 8'h11);
    tick(); set_req(4'd8, 2'd3, 2'd0, 8'h22);
    chk_link("starve.hA", 1'b1, 1'b1, 8'h13);
    tick(); set_req(4'd0, 2'd1, 2'd2, 8'h33);
    chk_link("starve.pA", 1'b1, 1'b0, 8'h11);
    tick(); no_req();
    chk_link("starve.hB", 1'b1, 1'b1, 8'h8C);
    tick();
    chk_link("starve.pB", 1'b1, 1'b0, 8'h22);
    tick();
    chk("starve.stall0", {15'd0, link_valid}, 16'd0);
    tick();
    chk("starve.stall1", {15'd0, link_valid}, 16'd0);

    // One credit: header of C, then held in BODY until the next credit.
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    set_req(4'd3, 2'd1, 2'd1, 8'h44);
    chk_link("starve.hC", 1'b1, 1'b1, 8'h06);
    tick(); no_req();
    chk("midstall.v0", {15'd0, link_valid}, 16'd0);
    tick();
    chk("midstall.v1", {15'd0, link_valid}, 16'd0);
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    chk_link("starve.pC", 1'b1, 1'b0, 8'h33);
    tick();
    chk("midstall.noD0", {15'd0, link_valid}, 16'd0);
    tick();
    chk("midstall.noD1", {15'd0, link_valid}, 16'd0);

    // FIFO full: D is queued, add E, F, G; a fifth request is ignored.
    set_req(4'd7, 2'd0, 2'd0, 8'h55);
    chk("full.ready_before", {15'd0, in_ready}, 16'd1);
    tick(); set_req(4'd2, 2'd2, 2'd2, 8'h66);
    tick(); set_req(4'd6, 2'd3, 2'd3, 8'h77);
    tick(); set_req(4'd4, 2'd0, 2'd0, 8'h99);
    chk("full.ready0", {15'd0, in_ready}, 16'd0);
    tick();
    chk("full.ready1", {15'd0, in_ready}, 16'd0);
    no_req();
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    chk_link("full.hD", 1'b1, 1'b1, 8'h35);
    chk("full.ready_hdr", {15'd0, in_ready}, 16'd0);
    tick();
    chk("full.bodystall", {15'd0, link_valid}, 16'd0);
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    chk_link("full.pD", 1'b1, 1'b0, 8'h44);
    chk("full.ready_back", {15'd0, in_ready}, 16'd1);

    // Drain E, F, G with a credit every cycle; the ignored request never appears.
    exp_v[0] = 1'b1; exp_h[0] = 1'b1; exp_f[0] = 8'h70;
    exp_v[1] = 1'b1; exp_h[1] = 1'b0; exp_f[1] = 8'h55;
    exp_v[2] = 1'b1; exp_h[2] = 1'b1; exp_f[2] = 8'h2A;
    exp_v[3] = 1'b1; exp_h[3] = 1'b0; exp_f[3] = 8'h66;
    exp_v[4] = 1'b1; exp_h[4] = 1'b1; exp_f[4] = 8'h6F;
    exp_v[5] = 1'b1; exp_h[5] = 1'b0; exp_f[5] = 8'h77;
    exp_v[6] = 1'b0; exp_h[6] = 1'b0; exp_f[6] = 8'h00;
    exp_v[7] = 1'b0; exp_h[7] = 1'b0; exp_f[7] = 8'h00;
    credit_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_link($sformatf("drain[%0d]", i), exp_v[i], exp_h[i], exp_f[i]);
    end
    credit_in = 1'b0;

    // Credits are now 2; top up to 4, then overflow.
    credit_in = 1'b1; tick(); tick(); credit_in = 1'b0;
    chk("ovf.before", {15'd0, credit_err}, 16'd0);
    tick();
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    chk("ovf.set", {15'd0, credit_err}, 16'd1);
    tick(); tick();
    chk("ovf.sticky", {15'd0, credit_err}, 16'd1);

    // Credits stayed at 4: exactly four flits go out for three packets.
    set_req(4'd1, 2'd0, 2'd3, 8'h11);
    tick(); set_req(4'd8, 2'd3, 2'd0, 8'h22);
    chk_link("ovf.hA", 1'b1, 1'b1, 8'h13);
    tick(); set_req(4'd0, 2'd1, 2'd2, 8'h33);
    chk_link("ovf.pA", 1'b1, 1'b0, 8'h11);
    tick(); no_req();
    chk_link("ovf.hB", 1'b1, 1'b1, 8'h8C);
    tick();
    chk_link("ovf.pB", 1'b1, 1'b0, 8'h22);
    tick();
    chk("ovf.limit", {15'd0, link_valid}, 16'd0);
    chk("ovf.sticky2", {15'd0, credit_err}, 16'd1);

    // Reset while holding C in BODY.
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    chk_link("rst.hC", 1'b1, 1'b1, 8'h06);
    tick();
    chk("rst.inbody", {15'd0, link_valid}, 16'd0);
    rst_n = 1'b0; tick();
    chk_reset_outputs("rst.mid");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst.nopay[%0d]", i), {15'd0, link_valid}, 16'd0);
    end

    // Fresh packet after reset goes out with full latency and credits.
    set_req(4'd5, 2'd2, 2'd1, 8'hA7);
    tick(); no_req();
    chk_link("post.hdr", 1'b1, 1'b1, 8'h59);
    tick();
    chk_link("post.pay", 1'b1, 1'b0, 8'hA7);
`ifdef COT_LINK_STATS_EN
    tick();
    chk("post.pkt_count", pkt_count, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
